// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with synchronous clamped load, combinational cascade
// carry/borrow, a one-cycle wrap pulse, and an optional saturating mode.
module mod_n_updown_counter #(
  parameter int WIDTH     = 3,
  parameter int MOD       = 6,
  parameter int RESET_VAL = 0,
  parameter int SATURATE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             borrow,
  output logic             wrapped,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] MAX_CNT   = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] RESET_CNT = WIDTH'(RESET_VAL);

  logic at_max;
  logic at_zero;

  assign at_max   = (count == MAX_CNT);
  assign at_zero  = (count == '0);
  assign at_limit = up ? at_max : at_zero;

  // Kept purely combinational so a chain of digits all advance on the same edge.
  assign carry  = en & up  & at_max  & ~load;
  assign borrow = en & ~up & at_zero & ~load;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= RESET_CNT;
      wrapped <= 1'b0;
    end else if (load) begin
      count   <= (load_val > MAX_CNT) ? MAX_CNT : load_val;
      wrapped <= 1'b0;
    end else if (en) begin
      wrapped <= 1'b0;
      if (up) begin
        if (at_max) begin
          if (SATURATE == 0) begin
            count   <= '0;
            wrapped <= 1'b1;
          end
        end else if (count > MAX_CNT) begin
          // Illegal state (X/SEU) recovers without signalling a wrap.
          count <= '0;
        end else begin
          count <= count + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          if (SATURATE == 0) begin
            count   <= MAX_CNT;
            wrapped <= 1'b1;
          end
        end else if (count > MAX_CNT) begin
          count <= MAX_CNT;
        end else begin
          count <= count - WIDTH'(1);
        end
      end
    end else begin
      wrapped <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Directed bench: wrapping mod-6, saturating mod-6 and a mod-10 -> mod-6 cascade.
module tb_mod_n_updown_counter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // Wrapping mod-6 instance
  logic       d_en, d_up, d_load;
  logic [2:0] d_lv, d_count;
  logic       d_carry, d_borrow, d_wrapped, d_at_limit;

  // Saturating mod-6 instance
  logic       s_en, s_up, s_load;
  logic [2:0] s_lv, s_count;
  logic       s_carry, s_borrow, s_wrapped, s_at_limit;

  // Cascade: mod-10 units feeding mod-6 tens
  logic       c_en, c_load;
  logic [3:0] u_lv, u_count;
  logic [2:0] t_lv, t_count;
  logic       u_carry, u_borrow, u_wrapped, u_at_limit;
  logic       t_carry, t_borrow, t_wrapped, t_at_limit;

  int checks = 0;
  int errors = 0;
  int pulses;

  mod_n_updown_counter #(.WIDTH(3), .MOD(6), .RESET_VAL(0), .SATURATE(0)) dut (
    .clk(clk), .rst(rst), .en(d_en), .up(d_up), .load(d_load), .load_val(d_lv),
    .count(d_count), .carry(d_carry), .borrow(d_borrow), .wrapped(d_wrapped),
    .at_limit(d_at_limit));

  mod_n_updown_counter #(.WIDTH(3), .MOD(6), .RESET_VAL(0), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .en(s_en), .up(s_up), .load(s_load), .load_val(s_lv),
    .count(s_count), .carry(s_carry), .borrow(s_borrow), .wrapped(s_wrapped),
    .at_limit(s_at_limit));

  mod_n_updown_counter #(.WIDTH(4), .MOD(10), .RESET_VAL(0), .SATURATE(0)) dut_units (
    .clk(clk), .rst(rst), .en(c_en), .up(1'b1), .load(c_load), .load_val(u_lv),
    .count(u_count), .carry(u_carry), .borrow(u_borrow), .wrapped(u_wrapped),
    .at_limit(u_at_limit));

  mod_n_updown_counter #(.WIDTH(3), .MOD(6), .RESET_VAL(0), .SATURATE(0)) dut_tens (
    .clk(clk), .rst(rst), .en(u_carry), .up(1'b1), .load(c_load), .load_val(t_lv),
    .count(t_count), .carry(t_carry), .borrow(t_borrow), .wrapped(t_wrapped),
    .at_limit(t_at_limit));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; inputs change and outputs are sampled 2 ns later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0;
    d_en = 1'b0; d_up = 1'b1; d_load = 1'b0; d_lv = 3'd0;
    s_en = 1'b0; s_up = 1'b1; s_load = 1'b0; s_lv = 3'd0;
    c_en = 1'b0; c_load = 1'b0; u_lv = 4'd0; t_lv = 3'd0;

    // Reset is asynchronous: values must appear before any clock edge.
    #3;
    check("rst_count_noclk", 32'(d_count), 32'd0);
    check("rst_wrapped_noclk", 32'(d_wrapped), 32'd0);
    d_en = 1'b1;
    tick();
    check("rst_hold_count", 32'(d_count), 32'd0);

    // Free-run up: 1,2,3,4,5,0
    rst = 1'b1;
    tick(); check("up_1", 32'(d_count), 32'd1);
    tick(); check("up_2", 32'(d_count), 32'd2);
    tick(); check("up_3", 32'(d_count), 32'd3);
    tick(); check("up_4", 32'(d_count), 32'd4);
    check("carry_at_4", 32'(d_carry), 32'd0);
    tick(); check("up_5", 32'(d_count), 32'd5);
    check("carry_at_5", 32'(d_carry), 32'd1);
    check("at_limit_5", 32'(d_at_limit), 32'd1);
    tick(); check("up_wrap_0", 32'(d_count), 32'd0);
    check("wrapped_up", 32'(d_wrapped), 32'd1);
    check("carry_after_wrap", 32'(d_carry), 32'd0);
    tick(); check("up_1b", 32'(d_count), 32'd1);
    check("wrapped_clear", 32'(d_wrapped), 32'd0);

    // Down-count wrap from a loaded 1: 1,0,5,4
    d_en = 1'b0; d_load = 1'b1; d_lv = 3'd1;
    tick(); check("load_1", 32'(d_count), 32'd1);
    d_load = 1'b0; d_en = 1'b1; d_up = 1'b0;
    #1 check("borrow_at_1", 32'(d_borrow), 32'd0);
    tick(); check("dn_0", 32'(d_count), 32'd0);
    check("borrow_at_0", 32'(d_borrow), 32'd1);
    check("at_limit_0_dn", 32'(d_at_limit), 32'd1);
    check("wrapped_dn_pre", 32'(d_wrapped), 32'd0);
    tick(); check("dn_wrap_5", 32'(d_count), 32'd5);
    check("wrapped_dn", 32'(d_wrapped), 32'd1);
    check("borrow_at_5", 32'(d_borrow), 32'd0);
    tick(); check("dn_4", 32'(d_count), 32'd4);
    check("wrapped_dn_once", 32'(d_wrapped), 32'd0);

    // Load priority over en, carry masked, clamp of out-of-range load value
    d_up = 1'b1;
    tick(); check("up_to_5", 32'(d_count), 32'd5);
    d_load = 1'b1; d_lv = 3'd3;
    #1 check("carry_masked_load", 32'(d_carry), 32'd0);
    tick(); check("load_over_en", 32'(d_count), 32'd3);
    d_lv = 3'd7;
    tick(); check("load_clamp", 32'(d_count), 32'd5);
    d_load = 1'b0; d_en = 1'b0;
    #1 check("carry_no_en", 32'(d_carry), 32'd0);
    tick(); check("hold_5", 32'(d_count), 32'd5);

    // Run to 4, then assert reset between edges
    d_en = 1'b1;
    tick(); check("run_0", 32'(d_count), 32'd0);
    tick(); tick(); tick(); tick();
    check("run_4", 32'(d_count), 32'd4);
    #1 rst = 1'b0;
    #1 check("async_rst_count", 32'(d_count), 32'd0);
    check("async_rst_wrapped", 32'(d_wrapped), 32'd0);
    tick(); check("rst_no_step", 32'(d_count), 32'd0);
    rst = 1'b1;
    tick(); check("post_rst_1", 32'(d_count), 32'd1);
    d_en = 1'b0;

    // Saturating mode: up from 4 holds at 5, down from 1 holds at 0
    s_load = 1'b1; s_lv = 3'd4;
    tick(); check("sat_load_4", 32'(s_count), 32'd4);
    s_load = 1'b0; s_en = 1'b1; s_up = 1'b1;
    tick(); check("sat_up_5", 32'(s_count), 32'd5);
    check("sat_carry_5", 32'(s_carry), 32'd1);
    tick(); check("sat_hold_5a", 32'(s_count), 32'd5);
    check("sat_wrapped_a", 32'(s_wrapped), 32'd0);
    check("sat_carry_5b", 32'(s_carry), 32'd1);
    tick(); check("sat_hold_5b", 32'(s_count), 32'd5);
    check("sat_wrapped_b", 32'(s_wrapped), 32'd0);
    s_load = 1'b1; s_lv = 3'd1;
    tick(); check("sat_load_1", 32'(s_count), 32'd1);
    s_load = 1'b0; s_up = 1'b0;
    tick(); check("sat_dn_0", 32'(s_count), 32'd0);
    check("sat_borrow_0", 32'(s_borrow), 32'd1);
    tick(); check("sat_hold_0", 32'(s_count), 32'd0);
    check("sat_wrapped_c", 32'(s_wrapped), 32'd0);
    s_en = 1'b0;

    // Cascade: 59 -> 00 on a single edge
    c_load = 1'b1; u_lv = 4'd9; t_lv = 3'd5;
    tick();
    check("casc_load_u", 32'(u_count), 32'd9);
    check("casc_load_t", 32'(t_count), 32'd5);
    c_load = 1'b0; c_en = 1'b1;
    #1 check("casc_u_carry", 32'(u_carry), 32'd1);
    check("casc_t_carry", 32'(t_carry), 32'd1);
    tick();
    check("casc_00_u", 32'(u_count), 32'd0);
    check("casc_00_t", 32'(t_count), 32'd0);
    check("casc_t_wrapped", 32'(t_wrapped), 32'd1);

    // 600 enabled cycles: back to 00 with ten tens wrap pulses
    pulses = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (t_wrapped) pulses++;
    end
    c_en = 1'b0;
    check("casc_600_u", 32'(u_count), 32'd0);
    check("casc_600_t", 32'(t_count), 32'd0);
    check("casc_600_pulses", 32'(pulses), 32'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
